// File: rtl/keypad_pkg.sv
// keypad_pkg: key map constants, FSM states and key-to-column/row lookups for the 4x4 keypad emulator
package keypad_pkg;
  localparam logic [3:0] COL_1 = 4'b0111;
  localparam logic [3:0] COL_2 = 4'b1011;
  localparam logic [3:0] COL_3 = 4'b1101;
  localparam logic [3:0] COL_4 = 4'b1110;
  localparam logic [3:0] ROW_1 = 4'b0111;
  localparam logic [3:0] ROW_2 = 4'b1011;
  localparam logic [3:0] ROW_3 = 4'b1101;
  localparam logic [3:0] ROW_4 = 4'b1110;
  localparam logic [3:0] NO_KEY = 4'b1111;
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
  function automatic logic [3:0] column_of(input logic [3:0] key);
    case (key)
      4'h1, 4'h4, 4'h7, 4'h0: column_of = COL_1;
      4'h2, 4'h5, 4'h8, 4'hF: column_of = COL_2;
      4'h3, 4'h6, 4'h9, 4'hE: column_of = COL_3;
      default:                column_of = COL_4;
    endcase
  endfunction
  function automatic logic [3:0] row_of(input logic [3:0] key);
    case (key)
      4'h1, 4'h2, 4'h3, 4'hA: row_of = ROW_1;
      4'h4, 4'h5, 4'h6, 4'hB: row_of = ROW_2;
      4'h7, 4'h8, 4'h9, 4'hC: row_of = ROW_3;
      default:                row_of = ROW_4;
    endcase
  endfunction
endpackage

// File: rtl/key_fifo.sv
// key_fifo: synchronous 4-bit FIFO; ports clk, rst_n (sync active-low), push/din, pop/dout, full, empty, count
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [3:0]               din,
  input  logic                     pop,
  output logic [3:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: queued key presses on a 4x4 matrix; key_code/key_valid/key_ready in, Col scan in, Row/busy/pressed_key/key_pressed out
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       busy,
  output logic [3:0] pressed_key,
  output logic       key_pressed
);
  localparam int MAX_CYC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  state_t                     state;
  logic [TW-1:0]              timer;
  logic [3:0]                 cur_key;
  logic [3:0]                 sync [SYNC_STAGES];
  logic [3:0]                 col_sync;
  logic [3:0]                 fifo_key;
  logic                       full, empty, pop;
  logic [$clog2(FIFO_DEPTH):0] count;
  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (key_valid),
    .din   (key_code),
    .pop   (pop),
    .dout  (fifo_key),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign pop       = state == IDLE && !empty;
  assign key_ready = !full;
  assign busy      = state != IDLE || count != '0;
  assign col_sync  = sync[SYNC_STAGES-1];
  // A key only answers its own column; any other pattern (idle, none, multiple) leaves rows released.
  function automatic logic [3:0] row_for(input logic [3:0] key);
    return col_sync == column_of(key) ? row_of(key) : NO_KEY;
  endfunction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= NO_KEY;
    end else begin
      sync[0] <= Col;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end
  // Row is updated together with the state so it is released exactly on PRESS exit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      cur_key     <= '0;
      Row         <= NO_KEY;
      pressed_key <= '0;
      key_pressed <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          state       <= PRESS;
          cur_key     <= fifo_key;
          timer       <= HOLD_LOAD;
          Row         <= row_for(fifo_key);
          pressed_key <= fifo_key;
          key_pressed <= 1'b1;
        end
        PRESS: if (timer == '0) begin
          state       <= GAP;
          timer       <= GAP_LOAD;
          Row         <= NO_KEY;
          pressed_key <= '0;
          key_pressed <= 1'b0;
        end else begin
          timer <= timer - 1'b1;
          Row   <= row_for(cur_key);
        end
        GAP: if (timer == '0) state <= IDLE;
             else timer <= timer - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: randomized and directed checks of keypad_emulator against a press-schedule model
module tb_keypad_emulator;
  localparam int H = 20;
  localparam int G = 10;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic [3:0] Col = 4'b1011;
  logic       key_ready, busy, key_pressed;
  logic [3:0] Row, pressed_key;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(D), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .Col         (Col),
    .Row         (Row),
    .busy        (busy),
    .pressed_key (pressed_key),
    .key_pressed (key_pressed)
  );
  // Physical layout: grid[r*4+c] is the key at row r, column c.
  logic [3:0] grid [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
  function automatic logic [3:0] col_code(input logic [3:0] k);
    for (int i = 0; i < 16; i++) if (grid[i] == k) return 4'hF ^ (4'h8 >> (i % 4));
    return 4'hF;
  endfunction
  function automatic logic [3:0] row_code(input logic [3:0] k);
    for (int i = 0; i < 16; i++) if (grid[i] == k) return 4'hF ^ (4'h8 >> (i / 4));
    return 4'hF;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Model: each accepted key gets push edge p and press-start edge s; press spans edges [s, s+H),
  // release gap follows, and the next key can start no earlier than s+H+G+1.
  int         now = 0;
  int         last_s = -1000;
  bit         model_on = 0;
  int         kp_q[$];
  int         ks_q[$];
  logic [3:0] kk_q[$];
  logic [3:0] col_hist [4];
  function automatic int occ(input int t);
    int n = 0;
    foreach (ks_q[i]) if (kp_q[i] <= t && t < ks_q[i]) n++;
    return n;
  endfunction
  always @(posedge clk) begin
    int s;
    now++;
    if (!rst_n) begin
      kp_q.delete();
      ks_q.delete();
      kk_q.delete();
      last_s = -1000;
      col_hist[now % 4] = 4'hF;
      model_on = 1;
    end else begin
      col_hist[now % 4] = Col;
      if (key_valid && occ(now - 1) < D) begin
        s = (now + 1 > last_s + H + G + 1) ? now + 1 : last_s + H + G + 1;
        kp_q.push_back(now);
        ks_q.push_back(s);
        kk_q.push_back(key_code);
        last_s = s;
      end
    end
  end
  logic [3:0] e_key, e_row;
  logic       e_kp, e_busy;
  always @(negedge clk) if (model_on) begin
    e_key = 4'h0; e_kp = 1'b0; e_busy = 1'b0; e_row = 4'hF;
    foreach (ks_q[i]) begin
      if (ks_q[i] <= now && now < ks_q[i] + H) begin
        e_kp = 1'b1;
        e_key = kk_q[i];
        if (col_hist[(now + 2) % 4] == col_code(kk_q[i])) e_row = row_code(kk_q[i]);
      end
      if (kp_q[i] <= now && now <= ks_q[i] + H + G - 1) e_busy = 1'b1;
    end
    chk("key_pressed", key_pressed, e_kp);
    chk("pressed_key", pressed_key, e_key);
    chk("busy", busy, e_busy);
    chk("key_ready", key_ready, occ(now) < D);
    chk("row", Row, e_row);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [3:0] k);
    logic acc = 1'b0;
    key_code = k;
    key_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = key_ready;
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("push_accept", acc, 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) tick(1);
    chk("idle_timeout", busy, 0);
  endtask
  logic [3:0] seq[$];
  int         gaps[$];
  logic [3:0] exp_seq [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h1};
  initial begin
    int cnt, cnt_row, cnt_e, cnt_bad, rel, col_left;
    logic prev_kp;
    tick(3);
    rst_n = 1'b1;
    // reset mid-PRESS discards the queued key
    push(4'h5);
    push(4'h7);
    tick(2);
    chk("t1_pressed", key_pressed, 1);
    chk("t1_key", pressed_key, 4'h5);
    chk("t1_row", Row, 4'b1011);
    rst_n = 1'b0;
    tick(1);
    chk("t1_rst_row", Row, 4'hF);
    chk("t1_rst_ready", key_ready, 1);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_kp", key_pressed, 0);
    rst_n = 1'b1;
    tick(5);
    chk("t1_flushed", busy, 0);
    // single press: rise two edges after the push, exactly H cycles of Row=1011
    wait_idle();
    push(4'h5);
    chk("t2_not_yet", key_pressed, 0);
    tick(1);
    chk("t2_rise", key_pressed, 1);
    chk("t2_row", Row, 4'b1011);
    cnt = 0; cnt_row = 0;
    repeat (40) begin
      if (key_pressed) cnt++;
      if (Row == 4'b1011) cnt_row++;
      tick(1);
    end
    chk("t2_hold_len", cnt, H);
    chk("t2_row_len", cnt_row, H);
    // rotating columns: D answers only on its own column
    wait_idle();
    Col = 4'b0111;
    push(4'hD);
    cnt_e = 0; cnt_bad = 0;
    repeat (3) foreach (exp_seq[j]) if (j < 4) begin
      Col = 4'hF ^ (4'h8 >> j);
      repeat (4) begin
        if (Row == 4'b1110) cnt_e++;
        else if (Row != 4'hF) cnt_bad++;
        tick(1);
      end
    end
    chk("t3_hits", cnt_e > 0, 1);
    chk("t3_bad_rows", cnt_bad, 0);
    // queue fill, order and inter-press release
    wait_idle();
    fork
      begin
        push(4'hA); push(4'hB); push(4'hC); push(4'hD); push(4'hE);
        chk("t4_full", key_ready, 0);
        push(4'h1);
      end
      begin
        prev_kp = 1'b0; rel = 0;
        for (int c = 0; c < 800 && seq.size() < 6; c++) begin
          if (key_pressed && !prev_kp) begin
            seq.push_back(pressed_key);
            if (seq.size() > 1) gaps.push_back(rel);
            rel = 0;
          end
          if (!key_pressed) rel++;
          prev_kp = key_pressed;
          tick(1);
        end
      end
    join
    chk("t4_count", seq.size(), 6);
    foreach (seq[i]) if (i < 6) chk("t4_order", seq[i], exp_seq[i]);
    foreach (gaps[i]) chk("t4_gap", gaps[i], G + 1);
    // invalid column patterns never answer
    wait_idle();
    Col = 4'b0000;
    push(4'h1);
    cnt_bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 8) Col = 4'b0011;
      if (Row != 4'hF) cnt_bad++;
      tick(1);
    end
    chk("t5_row_idle", cnt_bad, 0);
    // randomized traffic against the model
    col_left = 0;
    repeat (4000) begin
      key_valid = $urandom_range(0, 5) == 0;
      key_code = 4'($urandom);
      if (col_left <= 0) begin
        case ($urandom_range(0, 7))
          4: Col = 4'hF;
          5: Col = 4'h0;
          6, 7: Col = 4'($urandom);
          default: Col = 4'hF ^ (4'h8 >> $urandom_range(0, 3));
        endcase
        col_left = $urandom_range(1, 30);
      end
      col_left--;
      tick(1);
    end
    key_valid = 1'b0;
    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
